dose_scheduler: RTL and testbench
=================================

# dose_scheduler

Dose-timing controller for the medicine kit. Counts prescaled time per pill colour (red, green, yellow), raises a dose request whenever a colour's programmed interval elapses, and shares the single user-alert and confirm path between the three colours round-robin. Records per-colour taken and missed doses for the counter displays. Sits beside the slot-registration FSM, which owns slot codes; this block owns *when* each colour is due.

## Interface
- `TICK_DIV`, 50_000_000: clocks per schedule tick, ≥2.
- `TIMEOUT`, 30: ticks an alert waits for confirmation before the dose counts as missed, ≥1.
- `clkin`  in  1  system clock.
- `rst`  in  1  reset; one clock; reset is synchronous and active-high.
- `enable`  in  1  kit armed. Low = schedule halted and counts cleared.
- `cfg_we`  in  1  one-cycle write of `cfg_interval` to channel `cfg_sel`.
- `cfg_sel`  in  2  0 red, 1 green, 2 yellow; 3 ignored.
- `cfg_interval`  in  8  interval in ticks; 0 disables the channel.
- `ack`  in  1  one-cycle "dose taken" pulse, pre-debounced and synchronised.
- `alert`  out  1  user alert active.
- `alert_color`  out  2  colour being alerted; 3 = none.
- `pending`  out  3  due-dose bits {y,g,r}.
- `taken_cnt`  out  12  {y,g,r} 4-bit saturating counts.
- `missed_cnt`  out  12  {y,g,r} 4-bit saturating counts.
- `state_out`  out  2  FSM state.

## Operation
- Reset values: `alert` 0, `alert_color` 3, `pending` 0, all counts 0, intervals 0, countdowns 0, `state_out` IDLE (0), prescaler 0, RR pointer red.
- Prescaler: counts 0..TICK_DIV-1 while `enable`. Emits a one-cycle `tick` on wrap. Held at 0 while `!enable`.
- Config: `cfg_we` with `cfg_sel` < 3 loads the interval register and the countdown with `cfg_interval`. Accepted regardless of `enable`. `cfg_sel` = 3 has no effect.
- Countdown per channel: on `tick`, if interval ≠ 0, decrement. On a tick while countdown = 1, set `pending[c]` and reload the interval. An expiry on an already-pending channel is a no-op.
- Arbiter: picks among `pending` bits starting at the RR pointer. After a grant, the pointer moves to the colour after the granted one.
- FSM states:
  - IDLE = 0: if `enable` and `pending` ≠ 0, latch the granted colour into `alert_color`, clear the timeout counter, and go to ALERT.
  - ALERT = 1: `alert` = 1. The timeout counter increments on `tick`.
    - On `ack`: go to CLEAR and increment `taken_cnt[c]`.
    - Otherwise, when the timeout counter reaches TIMEOUT: go to CLEAR and increment `missed_cnt[c]`.
    - `ack` and timeout in the same cycle: `ack` wins; `missed_cnt` is unchanged.
  - CLEAR = 2: clear `pending[c]`, set `alert_color` to 3, return to IDLE. If the channel expires in this same cycle, the set wins and `pending[c]` stays 1.
- `ack` outside ALERT is ignored.
- Counts saturate at 15.
- `enable` low: next cycle the FSM is IDLE, `pending` = 0, all counts = 0, `alert` = 0, and countdowns reload from their intervals. Intervals are retained.
- `rst` mid-alert behaves as a full reset; intervals clear.

## Timing
- All outputs are registered (Moore).
- A tick at cycle N that expires a countdown gives `pending` = 1 at N+1, and `alert` plus `alert_color` at N+2 if the FSM is IDLE.
- `ack` at cycle M in ALERT gives CLEAR at M+1, with `taken_cnt` updated and `alert` = 0. IDLE follows at M+2. `pending` clears at M+2.
- Minimum gap between two alerts is 2 cycles (CLEAR, then IDLE).
- `enable` takes effect on the next clock edge.

## Structure
- Package `medikit_pkg`: colour encoding (`COL_RED`=0, `COL_GREEN`=1, `COL_YELLOW`=2, `COL_NONE`=3), FSM state encoding (IDLE, ALERT, CLEAR), and count width 4.
- Sub-module `rr_arbiter3`: 3-request round-robin arbiter with a registered pointer, advanced by a `grant_take` strobe.
- The prescaler, countdowns and FSM live in the top module.

## Test plan
All scenarios use TICK_DIV=4 and TIMEOUT=3.
- Reset, red interval 2, `enable` → on the 2nd tick `pending`=001; two cycles later `alert`=1 and `alert_color`=0. Pulse `ack` → `taken_cnt[3:0]`=1 and `alert`=0 one cycle later; `pending`=000.
- Red and green interval 2, same expiry → red alerted first; after `ack`, green alerted; pointer then favours yellow.
- Green interval 5, no `ack` → 3 ticks after the alert, `missed_cnt[7:4]`=1, `pending[1]`=0, `taken_cnt`=0.
- `ack` in the same cycle the timeout is reached → `taken_cnt` +1, `missed_cnt` unchanged.
- Drop `enable` during ALERT → next cycle IDLE, `alert`=0, `pending`=0, all counts 0. Re-enable → red alerts again after 2 ticks.
- Sixteen ack'd red doses → `taken_cnt[3:0]` holds at 15; `cfg_sel`=3 write leaves all intervals unchanged.

Source files
------------

// File: rtl/medikit_pkg.sv
// Shared encodings for the medicine-kit blocks: pill colours, dose FSM states and count width.
package medikit_pkg;

   typedef enum logic [1:0] {
      COL_RED    = 2'd0,
      COL_GREEN  = 2'd1,
      COL_YELLOW = 2'd2,
      COL_NONE   = 2'd3
   } color_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ALERT = 2'd1,
      CLEAR = 2'd2
   } state_e;

   localparam int CNT_W   = 4;
   localparam int NUM_COL = 3;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Three-request round-robin arbiter; the pointer moves past a colour only once its grant is taken.
module rr_arbiter3
   import medikit_pkg::*;
(
   input  logic       clk,
   input  logic       srst,
   input  logic [2:0] req_i,
   input  logic       grant_take_i,
   output logic       grant_valid_o,
   output logic [1:0] grant_idx_o
);

   logic [1:0] ptr_q, ptr_d;
   logic [1:0] cand0, cand1, cand2;

   function automatic logic [1:0] next_col(input logic [1:0] c);
      return (c == 2'd2) ? 2'd0 : c + 2'd1;
   endfunction

   assign cand0 = ptr_q;
   assign cand1 = next_col(cand0);
   assign cand2 = next_col(cand1);

   always_comb begin
      grant_valid_o = 1'b0;
      grant_idx_o   = COL_NONE;
      if (req_i[cand0]) begin
         grant_valid_o = 1'b1;
         grant_idx_o   = cand0;
      end else if (req_i[cand1]) begin
         grant_valid_o = 1'b1;
         grant_idx_o   = cand1;
      end else if (req_i[cand2]) begin
         grant_valid_o = 1'b1;
         grant_idx_o   = cand2;
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (grant_take_i && grant_valid_o) begin
         ptr_d = next_col(grant_idx_o);
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         ptr_q <= COL_RED;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/dose_scheduler.sv
// Per-colour dose timing: prescaled tick, interval countdowns, pending flags and a shared
// alert/confirm FSM with saturating taken/missed counters.
module dose_scheduler
   import medikit_pkg::*;
#(
   parameter int TICK_DIV = 50_000_000,
   parameter int TIMEOUT  = 30
)
(
   input  logic        clkin,
   input  logic        rst,
   input  logic        enable,
   input  logic        cfg_we,
   input  logic [1:0]  cfg_sel,
   input  logic [7:0]  cfg_interval,
   input  logic        ack,
   output logic        alert,
   output logic [1:0]  alert_color,
   output logic [2:0]  pending,
   output logic [11:0] taken_cnt,
   output logic [11:0] missed_cnt,
   output logic [1:0]  state_out
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
   localparam logic [TW-1:0] TO_LIM    = TW'(TIMEOUT);

   logic [PW-1:0] presc_q, presc_d;
   logic          tick;

   state_e        state_q, state_d;
   logic [1:0]    color_q, color_d;
   logic [TW-1:0] to_q, to_d;
   logic [11:0]   taken_q, taken_d, missed_q, missed_d;
   logic [2:0]    pend_bits;
   logic          grant_take, grant_valid;
   logic [1:0]    grant_idx;

   assign tick = enable && (presc_q == PRESC_MAX);

   always_comb begin
      presc_d = presc_q + 1'b1;
      if (!enable || tick) begin
         presc_d = '0;
      end
   end

   // Configuration outranks both the disable reload and a coincident tick.
   for (genvar gi = 0; gi < NUM_COL; gi++) begin : g_chan
      logic [7:0] interval_q, interval_d, countdown_q, countdown_d;
      logic       pending_q, pending_d, cfg_hit, expire;

      assign cfg_hit = cfg_we && (cfg_sel == 2'(gi));

      always_comb begin
         interval_d  = interval_q;
         countdown_d = countdown_q;
         expire      = 1'b0;
         if (cfg_hit) begin
            interval_d  = cfg_interval;
            countdown_d = cfg_interval;
         end else if (!enable) begin
            countdown_d = interval_q;
         end else if (tick && interval_q != 8'd0) begin
            if (countdown_q <= 8'd1) begin
               countdown_d = interval_q;
               expire      = 1'b1;
            end else begin
               countdown_d = countdown_q - 8'd1;
            end
         end
      end

      always_comb begin
         pending_d = pending_q;
         if (!enable) begin
            pending_d = 1'b0;
         end else if (expire) begin
            pending_d = 1'b1;
         end else if (state_q == CLEAR && color_q == 2'(gi)) begin
            pending_d = 1'b0;
         end
      end

      always_ff @(posedge clkin) begin
         if (rst) begin
            interval_q  <= '0;
            countdown_q <= '0;
            pending_q   <= 1'b0;
         end else begin
            interval_q  <= interval_d;
            countdown_q <= countdown_d;
            pending_q   <= pending_d;
         end
      end

      assign pend_bits[gi] = pending_q;
   end

   rr_arbiter3 u_arb (
      .clk           (clkin),
      .srst          (rst),
      .req_i         (pend_bits),
      .grant_take_i  (grant_take),
      .grant_valid_o (grant_valid),
      .grant_idx_o   (grant_idx)
   );

   always_comb begin
      state_d    = state_q;
      color_d    = color_q;
      to_d       = to_q;
      taken_d    = taken_q;
      missed_d   = missed_q;
      grant_take = 1'b0;
      if (!enable) begin
         state_d  = IDLE;
         color_d  = COL_NONE;
         to_d     = '0;
         taken_d  = '0;
         missed_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (grant_valid) begin
                  color_d    = grant_idx;
                  to_d       = '0;
                  state_d    = ALERT;
                  grant_take = 1'b1;
               end
            end
            ALERT: begin
               // A confirmation in the timeout cycle still counts as taken.
               if (ack) begin
                  state_d = CLEAR;
                  for (int k = 0; k < NUM_COL; k++) begin
                     if (color_q == 2'(k)) begin
                        taken_d[k*CNT_W +: CNT_W] = sat_inc(taken_q[k*CNT_W +: CNT_W]);
                     end
                  end
               end else if (to_q == TO_LIM) begin
                  state_d = CLEAR;
                  for (int k = 0; k < NUM_COL; k++) begin
                     if (color_q == 2'(k)) begin
                        missed_d[k*CNT_W +: CNT_W] = sat_inc(missed_q[k*CNT_W +: CNT_W]);
                     end
                  end
               end else if (tick) begin
                  to_d = to_q + 1'b1;
               end
            end
            CLEAR: begin
               color_d = COL_NONE;
               state_d = IDLE;
            end
            default: begin
               color_d = COL_NONE;
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clkin) begin
      if (rst) begin
         presc_q  <= '0;
         state_q  <= IDLE;
         color_q  <= COL_NONE;
         to_q     <= '0;
         taken_q  <= '0;
         missed_q <= '0;
      end else begin
         presc_q  <= presc_d;
         state_q  <= state_d;
         color_q  <= color_d;
         to_q     <= to_d;
         taken_q  <= taken_d;
         missed_q <= missed_d;
      end
   end

   assign alert       = (state_q == ALERT);
   assign alert_color = color_q;
   assign pending     = pend_bits;
   assign taken_cnt   = taken_q;
   assign missed_cnt  = missed_q;
   assign state_out   = state_q;

endmodule

// File: tb/tb_dose_scheduler.sv
// Bench for dose_scheduler: directed scenarios with literal expectations plus a random run,
// every cycle compared against a tick-counting reference model.
module tb_dose_scheduler;

   localparam int TD  = 4;
   localparam int TMO = 3;

   logic        clk = 1'b0;
   logic        rst, enable, cfg_we, ack;
   logic [1:0]  cfg_sel;
   logic [7:0]  cfg_interval;
   logic        alert;
   logic [1:0]  alert_color;
   logic [2:0]  pending;
   logic [11:0] taken_cnt, missed_cnt;
   logic [1:0]  state_out;

   dose_scheduler #(.TICK_DIV(TD), .TIMEOUT(TMO)) dut (
      .clkin        (clk),
      .rst          (rst),
      .enable       (enable),
      .cfg_we       (cfg_we),
      .cfg_sel      (cfg_sel),
      .cfg_interval (cfg_interval),
      .ack          (ack),
      .alert        (alert),
      .alert_color  (alert_color),
      .pending      (pending),
      .taken_cnt    (taken_cnt),
      .missed_cnt   (missed_cnt),
      .state_out    (state_out)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc_n  = 0;
   bit en_s   = 1'b0;

   // Reference model: ticks counted since enable, expiries as multiples of the interval.
   int m_ecyc;
   int m_iv[3];
   int m_since[3];
   int m_pend[3];
   int m_st;
   int m_col;
   int m_to;
   int m_taken[3];
   int m_missed[3];
   int m_ptr;

   task automatic model_step(input bit r, input bit e, input bit w, input int s, input int v,
                             input bit a);
      bit tk;
      int ex[3];
      int np[3];
      int g;
      if (r) begin
         m_ecyc = 0; m_st = 0; m_col = 3; m_to = 0; m_ptr = 0;
         for (int c = 0; c < 3; c++) begin
            m_iv[c] = 0; m_since[c] = 0; m_pend[c] = 0; m_taken[c] = 0; m_missed[c] = 0;
         end
         return;
      end
      tk = e && ((m_ecyc % TD) == TD - 1);
      m_ecyc = e ? m_ecyc + 1 : 0;
      for (int c = 0; c < 3; c++) begin
         ex[c] = 0;
         if (w && s == c) begin
            m_iv[c] = v;
            m_since[c] = 0;
         end else if (!e) begin
            m_since[c] = 0;
         end else if (tk && m_iv[c] != 0) begin
            m_since[c]++;
            if (m_since[c] % m_iv[c] == 0) ex[c] = 1;
         end
         if (!e) np[c] = 0;
         else if (ex[c] != 0) np[c] = 1;
         else if (m_st == 2 && m_col == c) np[c] = 0;
         else np[c] = m_pend[c];
      end
      if (!e) begin
         m_st = 0; m_col = 3; m_to = 0;
         for (int c = 0; c < 3; c++) begin
            m_taken[c] = 0; m_missed[c] = 0;
         end
      end else if (m_st == 0) begin
         g = -1;
         for (int k = 0; k < 3; k++) begin
            if (g < 0 && m_pend[(m_ptr + k) % 3] != 0) g = (m_ptr + k) % 3;
         end
         if (g >= 0) begin
            m_col = g; m_to = 0; m_st = 1; m_ptr = (g + 1) % 3;
         end
      end else if (m_st == 1) begin
         if (a) begin
            if (m_taken[m_col] < 15) m_taken[m_col]++;
            m_st = 2;
         end else if (m_to == TMO) begin
            if (m_missed[m_col] < 15) m_missed[m_col]++;
            m_st = 2;
         end else if (tk) begin
            m_to++;
         end
      end else begin
         m_col = 3; m_st = 0;
      end
      for (int c = 0; c < 3; c++) m_pend[c] = np[c];
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc_n, got, exp);
      end
   endtask

   task automatic compare_all();
      chk("alert", 32'(alert), 32'(m_st == 1));
      chk("alert_color", 32'(alert_color), 32'(m_col));
      chk("pending", 32'(pending), 32'((m_pend[2] << 2) | (m_pend[1] << 1) | m_pend[0]));
      chk("taken_cnt", 32'(taken_cnt), 32'((m_taken[2] << 8) | (m_taken[1] << 4) | m_taken[0]));
      chk("missed_cnt", 32'(missed_cnt),
          32'((m_missed[2] << 8) | (m_missed[1] << 4) | m_missed[0]));
      chk("state_out", 32'(state_out), 32'(m_st));
   endtask

   task automatic cyc(input bit r, input bit e, input bit w, input logic [1:0] s,
                      input logic [7:0] v, input bit a);
      rst = r; enable = e; cfg_we = w; cfg_sel = s; cfg_interval = v; ack = a;
      en_s = e;
      @(posedge clk);
      model_step(r, e, w, int'(s), int'(v), a);
      @(negedge clk);
      cyc_n++;
      $display("cyc=%0d rst=%0b en=%0b we=%0b sel=%0d iv=%0d ack=%0b | st=%0d alert=%0b col=%0d pend=%03b taken=%03h missed=%03h",
               cyc_n, r, e, w, s, v, a, state_out, alert, alert_color, pending, taken_cnt,
               missed_cnt);
      compare_all();
   endtask

   task automatic idle();
      cyc(1'b0, en_s, 1'b0, 2'd0, 8'd0, 1'b0);
   endtask

   task automatic do_reset();
      cyc(1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0);
   endtask

   task automatic wait_state(input logic [1:0] st, input int limit, input string name);
      int n = 0;
      while (state_out !== st && n < limit) begin
         idle();
         n++;
      end
      checks++;
      if (state_out !== st) begin
         errors++;
         $display("FAIL %s cycle=%0d got state=%0d expected state=%0d within %0d cycles",
                  name, cyc_n, state_out, st, limit);
      end
   endtask

   initial begin
      bit r, w, a;
      logic [1:0] s;
      logic [7:0] v;
      int n;

      // Reset values and a single red dose.
      do_reset();
      chk("rst_alert_color", 32'(alert_color), 32'd3);
      chk("rst_state", 32'(state_out), 32'd0);
      cyc(1'b0, 1'b1, 1'b1, 2'd0, 8'd2, 1'b0);
      repeat (7) idle();
      chk("s1_pending", 32'(pending), 32'b001);
      chk("s1_alert_early", 32'(alert), 32'd0);
      idle();
      chk("s1_alert", 32'(alert), 32'd1);
      chk("s1_color", 32'(alert_color), 32'd0);
      cyc(1'b0, 1'b1, 1'b0, 2'd0, 8'd0, 1'b1);
      chk("s1_taken", 32'(taken_cnt[3:0]), 32'd1);
      chk("s1_alert_off", 32'(alert), 32'd0);
      idle();
      chk("s1_pending_clr", 32'(pending), 32'b000);

      // Red and green due together: red first, then green.
      do_reset();
      cyc(1'b0, 1'b0, 1'b1, 2'd0, 8'd2, 1'b0);
      cyc(1'b0, 1'b1, 1'b1, 2'd1, 8'd2, 1'b0);
      wait_state(2'd1, 40, "s2_wait_first");
      chk("s2_first_color", 32'(alert_color), 32'd0);
      cyc(1'b0, 1'b1, 1'b0, 2'd0, 8'd0, 1'b1);
      wait_state(2'd1, 10, "s2_wait_second");
      chk("s2_second_color", 32'(alert_color), 32'd1);
      cyc(1'b0, 1'b1, 1'b0, 2'd0, 8'd0, 1'b1);
      repeat (4) idle();

      // Green times out unconfirmed.
      do_reset();
      cyc(1'b0, 1'b1, 1'b1, 2'd1, 8'd5, 1'b0);
      wait_state(2'd1, 40, "s3_wait_alert");
      chk("s3_color", 32'(alert_color), 32'd1);
      wait_state(2'd2, 20, "s3_wait_clear");
      chk("s3_missed", 32'(missed_cnt), 32'h010);
      chk("s3_taken", 32'(taken_cnt), 32'h000);
      idle();
      chk("s3_pending", 32'(pending[1]), 32'd0);

      // Confirmation in the very cycle the timeout is reached.
      do_reset();
      cyc(1'b0, 1'b1, 1'b1, 2'd0, 8'd2, 1'b0);
      wait_state(2'd1, 40, "s4_wait_alert");
      n = 0;
      while (!(m_st == 1 && m_to == TMO) && n < 40) begin
         idle();
         n++;
      end
      cyc(1'b0, 1'b1, 1'b0, 2'd0, 8'd0, 1'b1);
      chk("s4_taken", 32'(taken_cnt), 32'h001);
      chk("s4_missed", 32'(missed_cnt), 32'h000);

      // Disable during an alert, then re-enable.
      do_reset();
      cyc(1'b0, 1'b1, 1'b1, 2'd0, 8'd2, 1'b0);
      wait_state(2'd1, 40, "s5_wait_alert1");
      cyc(1'b0, 1'b1, 1'b0, 2'd0, 8'd0, 1'b1);
      wait_state(2'd1, 40, "s5_wait_alert2");
      cyc(1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0);
      chk("s5_state", 32'(state_out), 32'd0);
      chk("s5_alert", 32'(alert), 32'd0);
      chk("s5_pending", 32'(pending), 32'd0);
      chk("s5_taken", 32'(taken_cnt), 32'd0);
      en_s = 1'b1;
      repeat (8) idle();
      chk("s5_re_alert_early", 32'(alert), 32'd0);
      idle();
      chk("s5_re_alert", 32'(alert), 32'd1);
      chk("s5_re_color", 32'(alert_color), 32'd0);

      // Sixteen confirmed red doses saturate; a select-3 write changes nothing.
      do_reset();
      cyc(1'b0, 1'b1, 1'b1, 2'd0, 8'd1, 1'b0);
      for (int i = 0; i < 16; i++) begin
         wait_state(2'd1, 20, "s6_wait_alert");
         cyc(1'b0, 1'b1, 1'b0, 2'd0, 8'd0, 1'b1);
      end
      chk("s6_taken_sat", 32'(taken_cnt[3:0]), 32'd15);
      cyc(1'b0, 1'b1, 1'b1, 2'd3, 8'd7, 1'b0);
      repeat (20) idle();

      // Randomised run.
      do_reset();
      en_s = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         r = ($urandom_range(0, 499) == 0);
         if (en_s && $urandom_range(0, 149) == 0) en_s = 1'b0;
         else if (!en_s && $urandom_range(0, 7) == 0) en_s = 1'b1;
         w = ($urandom_range(0, 19) == 0);
         s = 2'($urandom_range(0, 3));
         v = 8'($urandom_range(0, 5));
         a = ($urandom_range(0, 5) == 0);
         cyc(r, en_s, w, s, v, a);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
